// File: rtl/line_mem_responder_if.sv
// line_mem_responder_if: line read/write request bus between an initiator and the line memory.
// Initiator drives rd_req, wr_req, addr, wr_line (held until gnt); the responder
// returns gnt, rd_line, busy, rd_count, wr_count and err.
interface line_mem_responder_if #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9
);
    localparam int LINE_W = 32 << LINE_ADDR_LEN;
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_LEN-1:0] addr;
    logic [LINE_W-1:0] wr_line;
    logic              gnt;
    logic [LINE_W-1:0] rd_line;
    logic              busy;
    logic [15:0]       rd_count;
    logic [15:0]       wr_count;
    logic              err;
    modport master (output rd_req, wr_req, addr, wr_line,
                    input  gnt, rd_line, busy, rd_count, wr_count, err);
    modport slave  (input  rd_req, wr_req, addr, wr_line,
                    output gnt, rd_line, busy, rd_count, wr_count, err);
endinterface

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency line memory answering one read or write line request at a time.
// Ports: clk, rst (async, active-high), bus (slave side of line_mem_responder_if).
module line_mem_responder #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int LATENCY       = 4
) (
    input  logic                clk,
    input  logic                rst,
    line_mem_responder_if.slave bus
);
    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int LINE_W    = 32 * LINE_SIZE;
    localparam int DEPTH     = 1 << ADDR_LEN;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic                op_wr_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   rd_line_q;
    logic [15:0]         rd_count_q;
    logic [15:0]         wr_count_q;
    logic                err_q;
    logic [LINE_W-1:0]   mem_q [DEPTH];
    // Lines never written read back their power-up pattern, so the array needs no preload.
    logic [DEPTH-1:0]    written_q = '0;

    logic                accept;
    logic                enter_done;
    logic                tx_wr;
    logic [ADDR_LEN-1:0] tx_addr;
    logic [LINE_W-1:0]   tx_line;

    function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_LEN-1:0] a);
        for (int w = 0; w < LINE_SIZE; w++)
            init_line[32*w +: 32] = 32'({a, w[LINE_ADDR_LEN-1:0]});
    endfunction

    // With LATENCY==1 completion happens on the accepting edge, before the latches hold the request.
    always_comb begin
        accept     = (state_q == IDLE) && (bus.rd_req || bus.wr_req);
        enter_done = (accept && LATENCY == 1) || (state_q == BUSY && cnt_q == 8'd1);
        tx_wr      = accept ? bus.wr_req : op_wr_q;
        tx_addr    = accept ? bus.addr : addr_q;
        tx_line    = accept ? bus.wr_line : line_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            line_q     <= '0;
            rd_line_q  <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= enter_done ? DONE : accept ? BUSY : (state_q == DONE) ? IDLE : state_q;
            cnt_q   <= accept ? 8'(LATENCY - 1) : cnt_q - 8'd1;
            if (accept) begin
                op_wr_q <= bus.wr_req;
                addr_q  <= bus.addr;
                line_q  <= bus.wr_line;
            end
            if (accept && bus.rd_req && bus.wr_req)
                err_q <= 1'b1;
            if (enter_done && tx_wr)
                wr_count_q <= wr_count_q + 16'd1;
            if (enter_done && !tx_wr) begin
                rd_count_q <= rd_count_q + 16'd1;
                rd_line_q  <= written_q[tx_addr] ? mem_q[tx_addr] : init_line(tx_addr);
            end
        end
    end

    // Array lives outside the reset domain; an asserted rst blocks the completing write.
    always_ff @(posedge clk) begin
        if (!rst && enter_done && tx_wr) begin
            mem_q[tx_addr]     <= tx_line;
            written_q[tx_addr] <= 1'b1;
        end
    end

    assign bus.gnt      = (state_q == DONE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.rd_line  = rd_line_q;
    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: vector table, directed corner cases and random traffic against a line-level model.
module tb_line_mem_responder;
    localparam int LS  = 8;
    localparam int LW  = 256;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_mem_responder_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(9)) bus ();
    line_mem_responder_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(9)) bus1 ();

    line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    int errors = 0;
    int checks = 0;

    logic [LW-1:0] model [512];
    logic [LW-1:0] exp_rd;
    int            exp_rc;
    int            exp_wc;
    logic          exp_err;

    typedef struct {
        logic        rd;
        logic        wr;
        int          addr;
        int          base;
        int          b2b;
        logic [31:0] w3;
        int          rc;
        int          wc;
        logic        err;
    } vec_t;
    vec_t tbl [8];

    function automatic logic [LW-1:0] pattern(input int a);
        logic [LW-1:0] p;
        for (int w = 0; w < LS; w++) p[32*w +: 32] = 32'(a * LS + w);
        return p;
    endfunction

    function automatic logic [LW-1:0] ramp(input int base);
        logic [LW-1:0] p;
        for (int w = 0; w < LS; w++) p[32*w +: 32] = 32'(base + w);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input int a, input logic [LW-1:0] l);
        bus.rd_req  = rd;
        bus.wr_req  = wr;
        bus.addr    = 9'(a);
        bus.wr_line = l;
    endtask

    task automatic drive1(input logic rd, input logic wr, input int a, input logic [LW-1:0] l);
        bus1.rd_req  = rd;
        bus1.wr_req  = wr;
        bus1.addr    = 9'(a);
        bus1.wr_line = l;
    endtask

    // Called on a negedge with the responder in IDLE (from_done=0) or DONE (from_done=1).
    task automatic run_txn(input logic rd, input logic wr, input int a, input logic [LW-1:0] l,
                           input int from_done, input bit drop);
        int exp_k;
        exp_k = LAT + from_done;
        drive(rd, wr, a, l);
        for (int k = 1; k <= exp_k; k++) begin
            @(negedge clk);
            if (drop && k == from_done + 1) drive(1'b0, 1'b0, a, l);
            if (k < exp_k) begin
                chk("gnt_early", LW'(bus.gnt), LW'(1'b0));
                chk("busy_wait", LW'(bus.busy), LW'(k > from_done));
            end
        end
        chk("gnt", LW'(bus.gnt), LW'(1'b1));
        if (wr) begin
            model[a] = l;
            exp_wc++;
            if (rd) exp_err = 1'b1;
        end else begin
            exp_rc++;
            exp_rd = model[a];
        end
        chk("rd_line", bus.rd_line, exp_rd);
        chk("rd_count", LW'(bus.rd_count), LW'(16'(exp_rc)));
        chk("wr_count", LW'(bus.wr_count), LW'(16'(exp_wc)));
        chk("err", LW'(bus.err), LW'(exp_err));
        chk("busy_done", LW'(bus.busy), LW'(1'b1));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0);
        @(negedge clk);
        chk("gnt_idle", LW'(bus.gnt), LW'(1'b0));
        chk("busy_idle", LW'(bus.busy), LW'(1'b0));
    endtask

    task automatic reset_expect();
        exp_rd  = '0;
        exp_rc  = 0;
        exp_wc  = 0;
        exp_err = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_gnt", LW'(bus.gnt), LW'(1'b0));
        chk("rst_busy", LW'(bus.busy), LW'(1'b0));
        chk("rst_rd_line", bus.rd_line, '0);
        chk("rst_rd_count", LW'(bus.rd_count), '0);
        chk("rst_wr_count", LW'(bus.wr_count), '0);
        chk("rst_err", LW'(bus.err), LW'(1'b0));
    endtask

    initial begin
        logic [LW-1:0] rl;
        bit            in_done;
        int            fd;
        int            op;
        tbl[0] = '{1'b1, 1'b0, 'h005, 0,    0, 32'h2B,  1, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 'h010, 'hA0, 0, 32'h2B,  1, 1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 'h010, 0,    1, 32'hA3,  2, 1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 'h011, 0,    0, 32'h8B,  3, 1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 'h001, 'h55, 0, 32'h8B,  3, 2, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 'h001, 0,    1, 32'h58,  4, 2, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 'h001, 0,    1, 32'h58,  5, 2, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 'h1FF, 0,    0, 32'hFFB, 6, 2, 1'b1};
        for (int a = 0; a < 512; a++) model[a] = pattern(a);
        reset_expect();
        drive(1'b0, 1'b0, 0, '0);
        drive1(1'b0, 1'b0, 0, '0);

        @(negedge clk);
        @(negedge clk);
        chk_reset_state();

        // Table: first entry issued on the very negedge rst falls.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, ramp(tbl[i].base), tbl[i].b2b, 1'b0);
            chk("tbl_w3", LW'(bus.rd_line[96 +: 32]), LW'(tbl[i].w3));
            chk("tbl_rc", LW'(bus.rd_count), LW'(16'(tbl[i].rc)));
            chk("tbl_wc", LW'(bus.wr_count), LW'(16'(tbl[i].wc)));
            chk("tbl_err", LW'(bus.err), LW'(tbl[i].err));
            if (i == 7 || tbl[i + 1].b2b == 0) idle();
        end

        // Random traffic on a small address pool for read-after-write hits.
        in_done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            for (int w = 0; w < LS; w++) rl[32*w +: 32] = $urandom;
            op = $urandom_range(0, 9);
            fd = (in_done && $urandom_range(0, 1) == 1) ? 1 : 0;
            if (in_done && fd == 0) idle();
            run_txn(op < 5, op >= 5, 'h10 + $urandom_range(0, 7), rl, fd, $urandom_range(0, 3) == 0);
            in_done = 1'b1;
        end
        idle();

        // Reset two cycles into a write: the write must not land.
        drive(1'b0, 1'b1, 'h020, ramp('hEE));
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_state();
        reset_expect();
        drive(1'b0, 1'b0, 0, '0);
        @(negedge clk);
        chk("gnt_in_rst", LW'(bus.gnt), LW'(1'b0));
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("gnt_after_abort", LW'(bus.gnt), LW'(1'b0));
        end
        chk("wr_count_abort", LW'(bus.wr_count), '0);
        run_txn(1'b1, 1'b0, 'h020, '0, 0, 1'b0);
        chk("abort_word0", LW'(bus.rd_line[31:0]), LW'(32'h100));
        idle();

        // Single-cycle-latency build: gnt one cycle after the request.
        drive1(1'b1, 1'b0, 'h005, '0);
        @(negedge clk);
        chk("l1_gnt_rd", LW'(bus1.gnt), LW'(1'b1));
        chk("l1_rd_w3", LW'(bus1.rd_line[96 +: 32]), LW'(32'h2B));
        chk("l1_rd_count", LW'(bus1.rd_count), LW'(16'd1));
        drive1(1'b0, 1'b0, 0, '0);
        @(negedge clk);
        chk("l1_gnt_off", LW'(bus1.gnt), LW'(1'b0));
        chk("l1_busy_off", LW'(bus1.busy), LW'(1'b0));
        drive1(1'b0, 1'b1, 'h007, ramp('hC0));
        @(negedge clk);
        chk("l1_gnt_wr", LW'(bus1.gnt), LW'(1'b1));
        chk("l1_wr_count", LW'(bus1.wr_count), LW'(16'd1));
        drive1(1'b1, 1'b0, 'h007, '0);
        @(negedge clk);
        chk("l1_done_ignored", LW'(bus1.gnt), LW'(1'b0));
        @(negedge clk);
        chk("l1_gnt_rd2", LW'(bus1.gnt), LW'(1'b1));
        chk("l1_rd2_w3", LW'(bus1.rd_line[96 +: 32]), LW'(32'hC3));
        chk("l1_rd_count2", LW'(bus1.rd_count), LW'(16'd2));
        drive1(1'b0, 1'b0, 0, '0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
